map_frame_ctrl: RTL
===================

# map_frame_ctrl

Frame sequencer for the MAP decoder datapath. It accepts the branch-metric symbols of one frame over a valid/ready handshake and writes them into the symbol buffer. It then drives the forward (alpha) recursion over all trellis steps, followed by the backward (beta) recursion with the LLR stage enabled. LLR outputs are tagged with valid/index after the LLR pipeline latency, and `done` pulses at the end of the frame.

## Interface
- `FRAME_LEN`, default 64: maximum trellis steps per frame.
- `ADDR_W`, default 6: symbol/metric buffer address width (2^ADDR_W ≥ FRAME_LEN).
- `LLR_LAT`, default 1: cycles from `llr_en` to a valid LLR bit; must be ≥1.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `frame_len` in ADDR_W+1: trellis steps L, latched on accepted `start`.
- `stall` in 1: freezes FWD/BWD stepping.
- `sym_valid` in 1: upstream symbol available.
- `sym_ready` out 1: controller accepts a symbol.
- `sym_wr_en` out 1: write the symbol buffer.
- `sym_addr` out ADDR_W: symbol write address.
- `alpha_en`, `alpha_init` out 1 each: step the alpha unit; `alpha_init` loads the known start state.
- `alpha_addr` out ADDR_W: trellis step for alpha.
- `beta_en`, `beta_init` out 1 each: step the beta unit; `beta_init` loads the terminal state.
- `beta_addr` out ADDR_W: trellis step for beta and LLR.
- `llr_en` out 1: LLR stage compute enable.
- `llr_valid` out 1: LLR bit valid.
- `llr_index` out ADDR_W: step index of the LLR bit.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle end-of-frame pulse.

## Operation
- States: IDLE → LOAD → FWD → BWD → DRAIN → DONE → IDLE. Step counter `k` is ADDR_W bits.
- **IDLE:** on `start`=1 with `frame_len`≠0, latch L = min(`frame_len`, FRAME_LEN), set k=0, go to LOAD. `start` with `frame_len`=0 is ignored. `start` in any other state is ignored.
- **LOAD:** `sym_ready`=1. `sym_wr_en` = `sym_valid`, `sym_addr` = k. Each accepted symbol increments k. When k=L-1 is accepted, go to FWD with k=0.
- **FWD:** when `stall`=0, `alpha_en`=1, `alpha_addr`=k, `alpha_init`=(k==0), and k increments. At k=L-1 unstalled, go to BWD with k=L-1.
- **BWD:** when `stall`=0, `beta_en`=`llr_en`=1, `beta_addr`=k, `beta_init`=(k==L-1), and k decrements. At k=0 unstalled, go to DRAIN.
- `stall`=1 in FWD/BWD: all enables 0 and k held. Stalls have no effect in other states.
- LLR delay line: LLR_LAT registers carrying {`llr_en`, `beta_addr`}. Output is {`llr_valid`, `llr_index`}. It shifts every cycle, including stalls (bubbles propagate).
- **DRAIN:** lasts exactly LLR_LAT cycles, then DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- All strobes are decoded from registered state and `k`. Only `sym_wr_en` depends combinationally on `sym_valid`.
- Unused addresses drive 0 when their enable is 0.

## Timing
- Reset: state IDLE, k=0, L=0, delay line cleared. Every output is 0 (`sym_ready`, `busy`, `done`, `llr_valid` included).
- Reset asserted mid-frame aborts within that edge. No `done` pulse and no further `llr_valid`.
- No stalls and `sym_valid` held high, with `start` at edge 0:
  - LOAD occupies cycles 1..L.
  - FWD occupies cycles L+1..2L.
  - BWD occupies cycles 2L+1..3L.
  - `llr_valid` occurs for indices L-1..0 at cycles 2L+1+LLR_LAT .. 3L+LLR_LAT.
  - `done` occurs at cycle 3L+LLR_LAT+1.
  - `busy` is high from cycle 1 through the `done` cycle.
- L=1 is legal: each phase lasts one cycle, and `alpha_init`/`beta_init` both assert on their single step.
- `start` is accepted again the cycle after `done`.

## Test plan
- **Basic frame:** L=4, LLR_LAT=1, `sym_valid`=1.
  - `sym_addr` sequence is 0,1,2,3; `alpha_addr` 0..3 with `alpha_init` only at 0; `beta_addr` 3,2,1,0 with `beta_init` only at 3.
  - `llr_index` 3,2,1,0 appears at cycles 10..13; `done` at cycle 14.
- **Throttled load:** L=3 with `sym_valid` pattern 1,0,0,1,0,1.
  - Exactly 3 writes, to addresses 0,1,2; FWD starts the cycle after the third accept.
- **Stalls:** L=4 with `stall`=1 for 2 cycles at FWD step 2 and 1 cycle at BWD step 1.
  - No enables during stalls; addresses resume unchanged; a one-cycle `llr_valid` gap appears.
  - `done` arrives 3 cycles later than in the basic frame.
- **Length boundaries:**
  - `frame_len`=0 leaves `busy`=0.
  - `frame_len`=100 with FRAME_LEN=64 runs 64 steps (`sym_addr` up to 63).
  - `frame_len`=1 produces `done` at cycle 5 with LLR_LAT=1.
- **Reset and restart:** assert `reset_n`=0 during BWD of an L=8 frame, with LLR_LAT=3.
  - All outputs are 0 the next cycle; no `llr_valid` or `done` follows.
  - A new `start` then runs a clean frame.
- **Start while busy:** pulse `start` during FWD.
  - The pulse is ignored and the current frame completes with unchanged timing.

Source files
------------

// File: rtl/map_frame_ctrl.sv
// Frame sequencer for the MAP decoder datapath.
// Loads one frame of branch-metric symbols, then runs the alpha recursion
// forward and the beta/LLR recursion backward.
// LLR results are tagged after a fixed pipeline delay, and done pulses at the end.
module map_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned LLR_LAT   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              stall,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic              sym_wr_en,
  output logic [ADDR_W-1:0] sym_addr,
  output logic              alpha_en,
  output logic              alpha_init,
  output logic [ADDR_W-1:0] alpha_addr,
  output logic              beta_en,
  output logic              beta_init,
  output logic [ADDR_W-1:0] beta_addr,
  output logic              llr_en,
  output logic              llr_valid,
  output logic [ADDR_W-1:0] llr_index,
  output logic              busy,
  output logic              done
);

  localparam int unsigned      LEN_W    = ADDR_W + 1;
  localparam int unsigned      DRN_W    = (LLR_LAT > 1) ? $clog2(LLR_LAT) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(FRAME_LEN);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LLR_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FWD,
    S_BWD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_W-1:0]       r_k;
  logic [ADDR_W-1:0]       w_k_nxt;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        w_len_nxt;
  logic [DRN_W-1:0]        r_drn;
  logic [DRN_W-1:0]        w_drn_nxt;
  logic [ADDR_W-1:0]       w_last;
  logic                    w_k_last;

  // LLR delay line: valid bit and step index, one stage per cycle of latency
  logic [LLR_LAT-1:0]             r_dl_vld;
  logic [LLR_LAT-1:0][ADDR_W-1:0] r_dl_idx;

  // Index of the final trellis step (L-1); L is never 0 outside IDLE
  assign w_last   = ADDR_W'(r_len - LEN_W'(1));
  assign w_k_last = (r_k == w_last);

  assign llr_valid = r_dl_vld[LLR_LAT-1];
  assign llr_index = r_dl_idx[LLR_LAT-1];

  // State, step counter, latched length and drain counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_len   <= '0;
      r_drn   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_len   <= w_len_nxt;
      r_drn   <= w_drn_nxt;
    end
  end

  // Next-state logic and strobe decode from registered state and k
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_len_nxt   = r_len;
    w_drn_nxt   = r_drn;
    sym_ready   = 1'b0;
    sym_wr_en   = 1'b0;
    sym_addr    = '0;
    alpha_en    = 1'b0;
    alpha_init  = 1'b0;
    alpha_addr  = '0;
    beta_en     = 1'b0;
    beta_init   = 1'b0;
    beta_addr   = '0;
    llr_en      = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (start && (frame_len != '0)) begin
          w_len_nxt   = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
          w_k_nxt     = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        sym_ready = 1'b1;
        sym_wr_en = sym_valid;
        sym_addr  = r_k;
        if (sym_valid) begin
          if (w_k_last) begin
            w_k_nxt     = '0;
            w_state_nxt = S_FWD;
          end else begin
            w_k_nxt = r_k + ADDR_W'(1);
          end
        end
      end
      S_FWD: begin
        if (!stall) begin
          alpha_en   = 1'b1;
          alpha_addr = r_k;
          alpha_init = (r_k == '0);
          if (w_k_last) begin
            w_k_nxt     = w_last;
            w_state_nxt = S_BWD;
          end else begin
            w_k_nxt = r_k + ADDR_W'(1);
          end
        end
      end
      S_BWD: begin
        if (!stall) begin
          beta_en   = 1'b1;
          llr_en    = 1'b1;
          beta_addr = r_k;
          beta_init = w_k_last;
          if (r_k == '0) begin
            w_drn_nxt   = '0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_k_nxt = r_k - ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Wait for the last LLR to leave the delay line
        if (r_drn == DRN_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_drn_nxt = r_drn + DRN_W'(1);
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // LLR delay line shifts every cycle so stall bubbles propagate as gaps
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_dl_vld <= '0;
      r_dl_idx <= '0;
    end else begin
      r_dl_vld[0] <= llr_en;
      r_dl_idx[0] <= beta_addr;
      for (int i = 1; i < int'(LLR_LAT); i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        r_dl_idx[i] <= r_dl_idx[i-1];
      end
    end
  end

endmodule
